rocev2_mul_pipe: RTL and testbench

- Parametrised pipelined multiply/multiply-accumulate unit for the rocev2 datapath.
- Generalises the fixed-width, fixed-depth, clock-enable-only unsigned multiplier. Adds:
  - configurable operand, accumulator and depth parameters;
  - per-beat signed/unsigned mode;
  - optional accumulate with clear;
  - a sideband tag;
  - valid/ready flow control with full-pipeline stall.
- Used for address/length scaling and packet-count arithmetic in the transport engines.

---
 rtl/rocev2_mul_pkg.sv | 30 +++
 rtl/rocev2_pipe_delay.sv | 62 ++++++
 rtl/rocev2_mul_pipe.sv | 177 +++++++++++++++++
 tb/tb_rocev2_mul_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocev2_mul_pkg.sv
// ---------------------------------------------------------------------------
// rocev2_mul_pkg
// Shared constants, types and helpers for the rocev2 pipelined multiplier.
//   MUL_MIN_STAGE / MUL_MAX_STAGE : legal range of the pipeline depth
//   mul_ctl_t                     : per-stage control payload
//   mul_prod_w()                  : width of the exact A x B product
// ---------------------------------------------------------------------------
package rocev2_mul_pkg;

    localparam int unsigned MUL_MIN_STAGE = 3;
    localparam int unsigned MUL_MAX_STAGE = 8;

    // Per-stage control payload; the tag rides next to it because its width
    // is a per-instance parameter.
    typedef struct packed {
        logic valid;
        logic is_signed;
        logic acc;
        logic acc_clr;
    } mul_ctl_t;

    localparam int unsigned MUL_CTL_W = $bits(mul_ctl_t);

    // Exact product width of an a_w x b_w multiply, signed or unsigned.
    function automatic int unsigned mul_prod_w(input int unsigned a_w,
                                               input int unsigned b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/rocev2_pipe_delay.sv
// ---------------------------------------------------------------------------
// rocev2_pipe_delay
// Register delay line of DEPTH stages carrying a valid bit and a data word.
// Only the valid bits are reset; data words are don't-care behind a clear
// valid. DEPTH = 0 collapses to a pure wire.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   en                    : advance all stages this cycle
//   in_valid, in_data     : word entering the line
//   out_valid, out_data   : word leaving the line
// ---------------------------------------------------------------------------
module rocev2_pipe_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        // Clock, reset and enable have no role in a zero-depth line.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset_n, en};

        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_regs
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] dat [DEPTH];

        // Valid shift register, cleared by reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld <= '0;
            end else if (en) begin
                for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                    vld[i] <= vld[i-1];
                end
                vld[0] <= in_valid;
            end
        end

        // Data shift register, no reset needed.
        always_ff @(posedge clk) begin
            if (en) begin
                for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                    dat[i] <= dat[i-1];
                end
                dat[0] <= in_data;
            end
        end

        assign out_valid = vld[DEPTH-1];
        assign out_data  = dat[DEPTH-1];
    end

endmodule

// File: rtl/rocev2_mul_pipe.sv
// ---------------------------------------------------------------------------
// rocev2_mul_pipe
// Pipelined signed/unsigned multiply and multiply-accumulate with a sideband
// tag and valid/ready flow control. Any output stall freezes every stage.
// Latency is NUM_STAGE cycles from acceptance to out_p when not stalled.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   in_valid / in_ready           : input handshake (in_ready combinational)
//   in_a, in_b                    : operands
//   in_signed                     : 1 = two's complement operands
//   in_acc, in_acc_clr            : accumulate / restart accumulator
//   in_tag                        : sideband returned with the result
//   out_valid / out_ready         : output handshake
//   out_p, out_tag                : result and its tag
// ---------------------------------------------------------------------------
module rocev2_mul_pipe
    import rocev2_mul_pkg::*;
#(
    parameter int unsigned A_W       = 10,
    parameter int unsigned B_W       = 8,
    parameter int unsigned ACC_W     = 18,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    input  logic             in_acc,
    input  logic             in_acc_clr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PROD_W    = mul_prod_w(A_W, B_W);
    localparam int unsigned DLY_DEPTH = NUM_STAGE - MUL_MIN_STAGE;
    localparam int unsigned DLY_W     = (MUL_CTL_W - 1) + TAG_W + PROD_W;

    if (NUM_STAGE < MUL_MIN_STAGE || NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_num_stage
        $error("rocev2_mul_pipe: NUM_STAGE outside 3..8");
    end
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("rocev2_mul_pipe: ACC_W narrower than A_W+B_W");
    end

    // Global stall: a held result freezes the whole pipe and the accumulator.
    logic stall_c;
    logic adv_c;

    assign stall_c  = out_valid && !out_ready;
    assign adv_c    = !stall_c;
    assign in_ready = adv_c;

    // Incoming control; clear is meaningless without accumulate, so drop it.
    mul_ctl_t in_ctl_c;

    always_comb begin
        in_ctl_c           = '0;
        in_ctl_c.valid     = in_valid;
        in_ctl_c.is_signed = in_signed;
        in_ctl_c.acc       = in_acc;
        in_ctl_c.acc_clr   = in_acc && in_acc_clr;
    end

    // Stage 1: operands, mode and tag.
    mul_ctl_t         s1_ctl;
    logic [A_W-1:0]   s1_a;
    logic [B_W-1:0]   s1_b;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_ctl <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else if (adv_c) begin
            s1_ctl <= in_ctl_c;
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_tag <= in_tag;
        end
    end

    // Exact product: operands are widened to PROD_W first so the low PROD_W
    // bits of the multiply hold the full result in either mode.
    logic signed [PROD_W-1:0] prod_s_c;
    logic        [PROD_W-1:0] prod_u_c;
    logic        [PROD_W-1:0] prod_c;

    assign prod_s_c = PROD_W'($signed(s1_a)) * PROD_W'($signed(s1_b));
    assign prod_u_c = PROD_W'(s1_a) * PROD_W'(s1_b);
    assign prod_c   = s1_ctl.is_signed ? $unsigned(prod_s_c) : prod_u_c;

    // Stage 2: registered product plus sideband.
    mul_ctl_t          s2_ctl;
    logic [TAG_W-1:0]  s2_tag;
    logic [PROD_W-1:0] s2_prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_ctl  <= '0;
            s2_tag  <= '0;
            s2_prod <= '0;
        end else if (adv_c) begin
            s2_ctl  <= s1_ctl;
            s2_tag  <= s1_tag;
            s2_prod <= prod_c;
        end
    end

    // Stages 3..NUM_STAGE-1: plain delay of product, mode and tag.
    logic              dl_valid;
    logic [DLY_W-1:0]  dl_data;
    logic              dl_is_signed;
    logic              dl_acc;
    logic              dl_acc_clr;
    logic [TAG_W-1:0]  dl_tag;
    logic [PROD_W-1:0] dl_prod;

    rocev2_pipe_delay #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (DLY_W)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (adv_c),
        .in_valid  (s2_ctl.valid),
        .in_data   ({s2_ctl.is_signed, s2_ctl.acc, s2_ctl.acc_clr, s2_tag, s2_prod}),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    assign {dl_is_signed, dl_acc, dl_acc_clr, dl_tag, dl_prod} = dl_data;

    // Extend the product to accumulator width and form the next accumulator.
    logic [ACC_W-1:0] ext_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [ACC_W-1:0] acc_q;

    always_comb begin
        ext_c = ACC_W'(dl_prod);
        if (dl_is_signed) begin
            ext_c = ACC_W'($signed(dl_prod));
        end
        acc_next_c = dl_acc_clr ? ext_c : (acc_q + ext_c);
    end

    // Output stage; the accumulator moves only with a valid beat, so
    // back-to-back accumulates chain through acc_q without a hazard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            acc_q     <= '0;
        end else if (adv_c) begin
            out_valid <= dl_valid;
            if (dl_valid) begin
                out_tag <= dl_tag;
                if (dl_acc) begin
                    acc_q <= acc_next_c;
                    out_p <= acc_next_c;
                end else begin
                    out_p <= ext_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_rocev2_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_rocev2_mul_pipe
// Bench for rocev2_mul_pipe: a default instance (ACC_W=18, NUM_STAGE=4) with
// a scoreboard fed by an arithmetic reference model, and a second instance
// (ACC_W=24, NUM_STAGE=3) for wide signed results and the zero-depth delay.
// ---------------------------------------------------------------------------
module tb_rocev2_mul_pipe;

    localparam int unsigned A_W    = 10;
    localparam int unsigned B_W    = 8;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned NS     = 4;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned ACC2_W = 24;
    localparam int unsigned NS2    = 3;
    localparam longint      MASK   = (longint'(1) << ACC_W) - 1;

    logic clk = 1'b0;
    logic reset_n;

    logic             in_valid, in_ready, in_signed, in_acc, in_acc_clr;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             out_valid, out_ready;
    logic [ACC_W-1:0] out_p;

    logic              in_valid2, in_ready2, in_signed2, in_acc2, in_acc_clr2;
    logic [A_W-1:0]    in_a2;
    logic [B_W-1:0]    in_b2;
    logic [TAG_W-1:0]  in_tag2, out_tag2;
    logic              out_valid2, out_ready2;
    logic [ACC2_W-1:0] out_p2;

    int errors = 0;
    int checks = 0;

    longint           exp_p_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    longint           log_p[$];
    logic [TAG_W-1:0] log_tag[$];
    longint           macc = 0;
    logic             prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_p;
    logic [TAG_W-1:0] prev_tag;

    always #5 clk = ~clk;

    rocev2_mul_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .NUM_STAGE(NS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .in_acc(in_acc), .in_acc_clr(in_acc_clr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag)
    );

    rocev2_mul_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC2_W), .NUM_STAGE(NS2), .TAG_W(TAG_W)
    ) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_signed(in_signed2),
        .in_acc(in_acc2), .in_acc_clr(in_acc_clr2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_p(out_p2), .out_tag(out_tag2)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Exact product from integer arithmetic, reduced modulo 2^acc_w.
    function automatic longint ref_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                        input logic sgn, input int unsigned acc_w);
        longint sa = longint'(a);
        longint sb = longint'(b);
        if (sgn && a[A_W-1]) sa -= (longint'(1) << A_W);
        if (sgn && b[B_W-1]) sb -= (longint'(1) << B_W);
        return (sa * sb) & ((longint'(1) << acc_w) - 1);
    endfunction

    // Scoreboard for the default instance, sampled mid-cycle.
    always @(negedge clk) begin
        longint pr;
        if (!reset_n) begin
            exp_p_q.delete();
            exp_tag_q.delete();
            macc       = 0;
            prev_stall = 1'b0;
        end else begin
            if (out_valid) begin
                if (prev_stall) begin
                    chk("hold_p", out_p, prev_p);
                    chk("hold_tag", out_tag, prev_tag);
                end
                chk("in_ready_vs_stall", in_ready, out_ready);
                if (out_ready) begin
                    log_p.push_back(out_p);
                    log_tag.push_back(out_tag);
                    if (exp_p_q.size() == 0) begin
                        chk("unexpected_out", out_valid, 1'b0);
                    end else begin
                        chk("out_p", out_p, exp_p_q.pop_front());
                        chk("out_tag", out_tag, exp_tag_q.pop_front());
                    end
                end
            end else begin
                chk("in_ready_idle", in_ready, 1'b1);
            end
            if (in_valid && in_ready) begin
                pr = ref_prod(in_a, in_b, in_signed, ACC_W);
                if (in_acc) begin
                    macc = in_acc_clr ? pr : ((macc + pr) & MASK);
                    exp_p_q.push_back(macc);
                end else begin
                    exp_p_q.push_back(pr);
                end
                exp_tag_q.push_back(in_tag);
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
            prev_tag   = out_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted.
    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic sgn, input logic acc, input logic clr,
                        input logic [TAG_W-1:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b;
        in_signed = sgn; in_acc = acc; in_acc_clr = clr; in_tag = tag;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", in_ready, 1'b1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_p_q.size() != 0; i++) tick();
        tick();
        chk("drain_empty", exp_p_q.size(), 0);
    endtask

    task automatic clear_log();
        log_p.delete();
        log_tag.delete();
    endtask

    // Stream n beats; either random valid/ready or a fixed out_ready-low window.
    task automatic stream(input int n_beats, input int stall_from, input int stall_len, input bit rnd);
        int sent = 0;
        bit took = 1'b1;
        for (int cyc = 0; cyc < 4000 && sent < n_beats; cyc++) begin
            if (took || !in_valid) begin
                in_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_a       = A_W'($urandom);
                in_b       = B_W'($urandom);
                in_signed  = 1'($urandom);
                in_acc     = 1'($urandom);
                in_acc_clr = ($urandom_range(0, 3) == 0);
                in_tag     = rnd ? TAG_W'($urandom) : TAG_W'(sent);
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0)
                            : !(cyc >= stall_from && cyc < stall_from + stall_len);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            tick();
        end
        chk("stream_sent", sent, n_beats);
        drain();
    endtask

    // Single signed beat on the wide, three-stage instance.
    task automatic one2(input string name, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input longint exp, input logic [TAG_W-1:0] tag);
        in_valid2 = 1'b1; in_a2 = a; in_b2 = b; in_signed2 = 1'b1; in_tag2 = tag;
        chk({name, "_in_ready"}, in_ready2, 1'b1);
        tick();
        in_valid2 = 1'b0;
        tick();
        chk({name, "_early"}, out_valid2, 1'b0);
        tick();
        chk({name, "_valid"}, out_valid2, 1'b1);
        chk(name, out_p2, exp);
        chk({name, "_tag"}, out_tag2, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        in_acc = 1'b0; in_acc_clr = 1'b0; in_tag = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_signed2 = 1'b0;
        in_acc2 = 1'b0; in_acc_clr2 = 1'b0; in_tag2 = '0; out_ready2 = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid2", out_valid2, 1'b0);
        chk("rst_out_p2", out_p2, 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // Unsigned max, latency of exactly NS cycles
        clear_log();
        send(10'd1023, 8'd255, 1'b0, 1'b0, 1'b0, 4'hA);
        repeat (NS - 2) tick();
        chk("t1_early", out_valid, 1'b0);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_p", out_p, 260865);
        chk("t1_tag", out_tag, 4'hA);
        drain();
        chk("t1_count", log_p.size(), 1);

        // Signed, wide accumulator and most-negative squared
        one2("t2_neg1x2", 10'h3FF, 8'h02, 24'hFFFFFE, 4'h3);
        one2("t2_minmin", 10'h200, 8'h80, 65536, 4'h4);
        clear_log();
        send(10'h3FF, 8'h02, 1'b1, 1'b0, 1'b0, 4'h1);
        send(10'h200, 8'h80, 1'b1, 1'b0, 1'b0, 4'h2);
        drain();
        chk("t2_count", log_p.size(), 2);
        chk("t2_neg1x2_18", log_p[0], 18'h3FFFE);
        chk("t2_minmin_18", log_p[1], 65536);

        // Back-to-back accumulate chain, plain beat leaves accumulator alone
        clear_log();
        send(10'd10, 8'd10, 1'b0, 1'b1, 1'b1, 4'h1);
        send(10'd20, 8'd3,  1'b0, 1'b1, 1'b0, 4'h2);
        send(10'd5,  8'd5,  1'b0, 1'b1, 1'b0, 4'h3);
        send(10'd2,  8'd2,  1'b0, 1'b0, 1'b1, 4'h4);
        send(10'd0,  8'd0,  1'b0, 1'b1, 1'b0, 4'h5);
        drain();
        chk("t3_count", log_p.size(), 5);
        chk("t3_acc0", log_p[0], 100);
        chk("t3_acc1", log_p[1], 160);
        chk("t3_acc2", log_p[2], 185);
        chk("t3_plain", log_p[3], 4);
        chk("t3_acc_kept", log_p[4], 185);

        // Accumulator wrap
        clear_log();
        send(10'd1023, 8'd255, 1'b0, 1'b1, 1'b1, 4'h6);
        send(10'd1023, 8'd255, 1'b0, 1'b1, 1'b0, 4'h7);
        drain();
        chk("t4_count", log_p.size(), 2);
        chk("t4_first", log_p[0], 260865);
        chk("t4_wrap", log_p[1], 259586);

        // Backpressure window mid-stream, tags carry the send order
        clear_log();
        stream(8, 5, 5, 1'b0);
        chk("t5_count", log_p.size(), 8);
        for (int i = 0; i < 8; i++) chk("t5_order", log_tag[i], TAG_W'(i));

        // Random traffic and random backpressure
        stream(200, 0, 0, 1'b1);

        // Reset with beats in flight
        out_ready = 1'b1;
        send(10'd7, 8'd9, 1'b0, 1'b1, 1'b1, 4'h1);
        send(10'd2, 8'd2, 1'b0, 1'b1, 1'b0, 4'h2);
        send(10'd3, 8'd3, 1'b0, 1'b1, 1'b0, 4'h3);
        tick();
        chk("t6_pre_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_p", out_p, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NS + 2; i++) begin
            tick();
            chk("t6_no_ghost", out_valid, 1'b0);
        end
        clear_log();
        send(10'd3, 8'd4, 1'b0, 1'b1, 1'b0, 4'h9);
        drain();
        chk("t6_count", log_p.size(), 1);
        chk("t6_acc_cleared", log_p[0], 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
